fifo_packer: RTL and testbench

Width up-converter on the read side of the action's `fifo`: accepts narrow words via valid/ready, packs C_RATIO of them into one wide beat, and forwards the beat through a registered output stage. A last-word marker closes a partial beat early, with a word count. It feeds the wide datapath of the cgemm action while the narrow FIFO buffers bursty input.

---
 rtl/fifo_packer.sv | 105 ++++++++++
 tb/tb_fifo_packer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// fifo_packer
//   Width up-converter for the read side of the narrow FIFO. Collects
//   C_RATIO narrow words into one wide beat. A word flagged IN_LAST closes
//   the beat early. The finished beat sits in a registered output stage
//   until the consumer takes it.
//
// Ports
//   CLK, RST    clock; asynchronous active-high reset
//   IN_DATA     narrow input word
//   IN_VALID    input word valid
//   IN_LAST     final word of a transfer, qualified by IN_VALID
//   IN_READY    word accepted on IN_VALID & IN_READY
//   OUT_DATA    packed beat, word k at [k*C_IN_WIDTH +: C_IN_WIDTH]
//   OUT_WORDS   number of valid words in the beat (1..C_RATIO)
//   OUT_LAST    beat holds the final word of a transfer
//   OUT_VALID   beat valid
//   OUT_READY   beat consumed on OUT_VALID & OUT_READY
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that edge.
// Ready may depend on the other side's ready but never on valid.
module fifo_packer #(
  parameter int C_IN_WIDTH = 32,
  parameter int C_RATIO    = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [C_IN_WIDTH-1:0]         IN_DATA,
  input  logic                          IN_VALID,
  input  logic                          IN_LAST,
  output logic                          IN_READY,
  output logic [C_IN_WIDTH*C_RATIO-1:0] OUT_DATA,
  output logic [$clog2(C_RATIO):0]      OUT_WORDS,
  output logic                          OUT_LAST,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY
);

  localparam int CW = $clog2(C_RATIO);
  localparam int OW = C_IN_WIDTH * C_RATIO;

  logic [CW-1:0]         rCount;
  logic [C_IN_WIDTH-1:0] rAcc [C_RATIO];

  logic          accept;
  logic          complete;
  logic [OW-1:0] nextBeat;

  // The input may advance only when the output register is free, or when
  // it is emptying on this edge. The term is gated with RST so that the
  // input side looks stalled for the whole time reset is held.
  assign IN_READY = ~RST & (~OUT_VALID | OUT_READY);
  assign accept   = IN_VALID & IN_READY;
  assign complete = (rCount == CW'(C_RATIO - 1)) | IN_LAST;

  // Build the beat that would be loaded on a completing word. Slots below
  // rCount come from the accumulator. Slot rCount takes the live word.
  // Slots above rCount are forced to zero, so a short beat never carries
  // stale data.
  always_comb begin
    nextBeat = '0;
    for (int k = 0; k < C_RATIO; k++) begin
      if (CW'(k) < rCount)
        nextBeat[k*C_IN_WIDTH +: C_IN_WIDTH] = rAcc[k];
      else if (CW'(k) == rCount)
        nextBeat[k*C_IN_WIDTH +: C_IN_WIDTH] = IN_DATA;
    end
  end

  // Slot counter and accumulator.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rCount <= '0;
      for (int k = 0; k < C_RATIO; k++) rAcc[k] <= '0;
    end else if (accept) begin
      if (complete) begin
        rCount <= '0;
        for (int k = 0; k < C_RATIO; k++) rAcc[k] <= '0;
      end else begin
        rCount       <= rCount + 1'b1;
        rAcc[rCount] <= IN_DATA;
      end
    end
  end

  // Output register. A completing word can be accepted on the same edge
  // that the old beat leaves. In that case the new beat replaces the old
  // one and OUT_VALID stays high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_DATA  <= '0;
      OUT_WORDS <= '0;
      OUT_LAST  <= 1'b0;
      OUT_VALID <= 1'b0;
    end else if (accept && complete) begin
      OUT_DATA  <= nextBeat;
      OUT_WORDS <= (CW+1)'(rCount) + (CW+1)'(1);
      OUT_LAST  <= IN_LAST;
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_packer.sv
module tb_fifo_packer;

  localparam int W  = 32;
  localparam int R  = 4;
  localparam int OW = W * R;
  localparam int WW = $clog2(R) + 1;
  localparam int BW = 1 + WW + OW;

  logic          CLK;
  logic          RST;
  logic [W-1:0]  IN_DATA;
  logic          IN_VALID;
  logic          IN_LAST;
  logic          IN_READY;
  logic [OW-1:0] OUT_DATA;
  logic [WW-1:0] OUT_WORDS;
  logic          OUT_LAST;
  logic          OUT_VALID;
  logic          OUT_READY;

  fifo_packer #(.C_IN_WIDTH(W), .C_RATIO(R)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_LAST   (IN_LAST),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_WORDS (OUT_WORDS),
    .OUT_LAST  (OUT_LAST),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int            hs_cyc_q[$];
  int            n_checks  = 0;
  int            n_errors  = 0;
  int            n_waits   = 0;
  int            n_beats   = 0;
  int            n_pushed  = 0;

  function automatic logic [BW-1:0] mk_beat(input logic [OW-1:0] d,
                                            input int words,
                                            input logic last);
    return {last, WW'(words), d};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [BW-1:0] b);
    exp_q.push_back(b);
    n_pushed++;
  endtask

  // Monitor: outputs are sampled on the falling edge. Inputs change only
  // just after a rising edge, so a beat that is valid and ready here
  // transfers on the next rising edge.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      logic [BW-1:0] e;
      n_beats++;
      hs_cyc_q.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL beat_unexpected: got data=%0h words=%0d last=%0b expected none",
                 OUT_DATA, OUT_WORDS, OUT_LAST);
      end else begin
        e = exp_q.pop_front();
        if ({OUT_LAST, OUT_WORDS, OUT_DATA} !== e) begin
          n_errors++;
          $display("FAIL beat: got last=%0b words=%0d data=%0h expected last=%0b words=%0d data=%0h",
                   OUT_LAST, OUT_WORDS, OUT_DATA, e[BW-1], e[OW +: WW], e[OW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one word and holds it until it is accepted. Returns just
  // after the accepting edge with IN_VALID dropped. A following call at
  // the same time re-asserts IN_VALID, so words can go back to back.
  task automatic drive_word(input logic [W-1:0] d, input logic last);
    int budget;
    budget   = 0;
    IN_DATA  = d;
    IN_LAST  = last;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && budget < 200) begin
      n_waits++;
      budget++;
      @(negedge CLK);
    end
    if (!IN_READY) begin
      n_checks++;
      n_errors++;
      $display("FAIL drive_timeout: got IN_READY=0 expected 1 within 200 cycles");
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge CLK);
      budget++;
    end
    #1;
    check(name, OW'(exp_q.size()), OW'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [OW-1:0] beat1;
  logic [OW-1:0] acc;
  logic [W-1:0]  w;
  int            slot;

  initial begin
    RST       = 1'b1;
    IN_DATA   = '0;
    IN_VALID  = 1'b0;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b1;

    // Reset state while RST is held
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", OW'(OUT_VALID), OW'(0));
    check("rst_out_data",  OUT_DATA,       OW'(0));
    check("rst_out_words", OW'(OUT_WORDS), OW'(0));
    check("rst_out_last",  OW'(OUT_LAST),  OW'(0));
    check("rst_in_ready",  OW'(IN_READY),  OW'(0));
    RST = 1'b0;
    #1;
    check("rel_in_ready",  OW'(IN_READY),  OW'(1));
    idle(2);

    // Full beat
    push_exp(mk_beat(128'h44444444_33333333_22222222_11111111, 4, 1'b0));
    drive_word(32'h11111111, 1'b0);
    drive_word(32'h22222222, 1'b0);
    drive_word(32'h33333333, 1'b0);
    drive_word(32'h44444444, 1'b0);
    wait_drain("full_drain");

    // Partial beat. IN_LAST without IN_VALID must not close the beat.
    push_exp(mk_beat(128'h00000000_00000000_0000000B_0000000A, 2, 1'b1));
    drive_word(32'h0000000A, 1'b0);
    IN_LAST = 1'b1;
    idle(2);
    IN_LAST = 1'b0;
    check("last_no_valid_ignored", OW'(OUT_VALID), OW'(0));
    drive_word(32'h0000000B, 1'b1);
    wait_drain("partial_drain");

    // IN_LAST on the first word of a beat
    push_exp(mk_beat(128'h0000000000000000_0000000000000000_0000000000000000_00000000DEADBEEF & 128'hFFFFFFFF, 1, 1'b1));
    drive_word(32'hDEADBEEF, 1'b1);
    wait_drain("single_drain");

    // Backpressure: beat 1 held for 5 stalled cycles with a word pending
    OUT_READY = 1'b0;
    beat1 = 128'h00000104_00000103_00000102_00000101;
    push_exp(mk_beat(beat1, 4, 1'b0));
    push_exp(mk_beat(128'h00000108_00000107_00000106_00000105, 4, 1'b1));
    drive_word(32'h00000101, 1'b0);
    drive_word(32'h00000102, 1'b0);
    drive_word(32'h00000103, 1'b0);
    drive_word(32'h00000104, 1'b0);
    IN_DATA  = 32'h00000105;
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_in_ready",  OW'(IN_READY),  OW'(0));
      check("stall_out_valid", OW'(OUT_VALID), OW'(1));
      check("stall_out_data",  OUT_DATA,       beat1);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    #1;
    check("unstall_in_ready", OW'(IN_READY), OW'(1));
    drive_word(32'h00000105, 1'b0);
    drive_word(32'h00000106, 1'b0);
    drive_word(32'h00000107, 1'b0);
    drive_word(32'h00000108, 1'b1);
    wait_drain("bp_drain");

    // Old beat leaves and a new beat loads on the same edge
    OUT_READY = 1'b0;
    push_exp(mk_beat(OW'(32'h000000C1), 1, 1'b1));
    push_exp(mk_beat(OW'(32'h000000C2), 1, 1'b1));
    drive_word(32'h000000C1, 1'b1);
    OUT_READY = 1'b1;
    drive_word(32'h000000C2, 1'b1);
    check("swap_out_valid", OW'(OUT_VALID), OW'(1));
    check("swap_out_data",  OUT_DATA,       OW'(32'h000000C2));
    wait_drain("swap_drain");

    // Streaming: 64 random words, 16 beats, one beat every R cycles
    n_waits = 0;
    hs_cyc_q.delete();
    acc  = '0;
    slot = 0;
    for (int i = 0; i < 64; i++) begin
      w = W'($urandom_range(32'hFFFF_FFFF, 0));
      acc[slot*W +: W] = w;
      if (slot == R - 1) begin
        push_exp(mk_beat(acc, R, 1'b0));
        acc  = '0;
        slot = 0;
      end else begin
        slot++;
      end
      drive_word(w, 1'b0);
    end
    wait_drain("stream_drain");
    check("stream_waits", OW'(n_waits), OW'(0));
    check("stream_beats", OW'(hs_cyc_q.size()), OW'(16));
    for (int i = 1; i < hs_cyc_q.size(); i++)
      check("stream_gap", OW'(hs_cyc_q[i] - hs_cyc_q[i-1]), OW'(R));

    // Reset mid-beat: the 3 partial words are discarded
    drive_word(32'hBAD00001, 1'b0);
    drive_word(32'hBAD00002, 1'b0);
    drive_word(32'hBAD00003, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("midrst_out_valid", OW'(OUT_VALID), OW'(0));
    check("midrst_out_words", OW'(OUT_WORDS), OW'(0));
    check("midrst_in_ready",  OW'(IN_READY),  OW'(0));
    #2;
    RST = 1'b0;
    #1;
    check("midrel_in_ready",  OW'(IN_READY),  OW'(1));
    idle(3);
    check("midrel_no_beat",   OW'(OUT_VALID), OW'(0));
    push_exp(mk_beat(128'h0000A004_0000A003_0000A002_0000A001, 4, 1'b0));
    drive_word(32'h0000A001, 1'b0);
    drive_word(32'h0000A002, 1'b0);
    drive_word(32'h0000A003, 1'b0);
    drive_word(32'h0000A004, 1'b0);
    wait_drain("midrst_drain");

    idle(5);
    check("total_beats", OW'(n_beats), OW'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
